// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: clips drawer pixels, maps them to linear addresses and queues framebuffer writes (optional clip counter: FB_WRITER_CLIP_CNT_EN)
module fb_pixel_writer #(
    parameter int CORDW  = 16,
    parameter int COLRW  = 4,
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 180,
    parameter int ADDRW  = 16,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [CORDW-1:0] x,
    input  logic signed [CORDW-1:0] y,
    input  logic                    drawing,
    input  logic [COLRW-1:0]        colr,
    output logic                    oe,
    output logic                    fb_we,
    output logic [ADDRW-1:0]        fb_addr,
    output logic [COLRW-1:0]        fb_colr,
    input  logic                    fb_ready,
    input  logic                    clear,
    output logic                    idle,
    output logic                    overflow,
    output logic [15:0]             clip_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic signed [CORDW-1:0] W_S = CORDW'(WIDTH);
    localparam logic signed [CORDW-1:0] H_S = CORDW'(HEIGHT);

    logic                   stage_valid_q, stage_valid_d;
    logic [ADDRW-1:0]       stage_addr_q, stage_addr_d;
    logic [COLRW-1:0]       stage_colr_q, stage_colr_d;
    logic [ADDRW-1:0]       mem_addr_q [DEPTH];
    logic [ADDRW-1:0]       mem_addr_d [DEPTH];
    logic [COLRW-1:0]       mem_colr_q [DEPTH];
    logic [COLRW-1:0]       mem_colr_d [DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   overflow_q, overflow_d;
    logic                   in_range, pop, full, push;

    always_comb begin
        in_range      = drawing && !x[CORDW-1] && !y[CORDW-1] && x < W_S && y < H_S;
        pop           = cnt_q != '0 && fb_ready;
        full          = cnt_q == CW'(DEPTH);
        push          = stage_valid_q && (!full || pop);
        stage_valid_d = in_range;
        stage_addr_d  = in_range ? ADDRW'(y) * ADDRW'(WIDTH) + ADDRW'(x) : stage_addr_q;
        stage_colr_d  = in_range ? colr : stage_colr_q;
        mem_addr_d    = mem_addr_q;
        mem_colr_d    = mem_colr_q;
        if (push) begin
            mem_addr_d[wr_ptr_q] = stage_addr_q;
            mem_colr_d[wr_ptr_q] = stage_colr_q;
        end
        wr_ptr_d      = wr_ptr_q + PW'(push);
        rd_ptr_d      = rd_ptr_q + PW'(pop);
        cnt_d         = cnt_q + CW'(push) - CW'(pop);
        // a full FIFO that pops this edge still has room for the stage entry
        overflow_d    = !clear && (overflow_q || (stage_valid_q && full && !pop));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid_q <= 1'b0;
            stage_addr_q  <= '0;
            stage_colr_q  <= '0;
            mem_addr_q    <= '{default: '0};
            mem_colr_q    <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
            overflow_q    <= 1'b0;
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_addr_q  <= stage_addr_d;
            stage_colr_q  <= stage_colr_d;
            mem_addr_q    <= mem_addr_d;
            mem_colr_q    <= mem_colr_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
            overflow_q    <= overflow_d;
        end
    end

    assign oe       = cnt_q + CW'(stage_valid_q) <= CW'(DEPTH - 2);
    assign fb_we    = cnt_q != '0;
    assign fb_addr  = mem_addr_q[rd_ptr_q];
    assign fb_colr  = mem_colr_q[rd_ptr_q];
    assign idle     = !stage_valid_q && cnt_q == '0;
    assign overflow = overflow_q;

`ifdef FB_WRITER_CLIP_CNT_EN
    logic [15:0] clip_cnt_q, clip_cnt_d;

    always_comb
        clip_cnt_d = clear ? '0
                   : (drawing && !in_range && clip_cnt_q != 16'hFFFF) ? clip_cnt_q + 16'd1
                   : clip_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clip_cnt_q <= '0;
        else        clip_cnt_q <= clip_cnt_d;
    end

    assign clip_cnt = clip_cnt_q;
`else
    assign clip_cnt = '0;
`endif
endmodule

// File: doc/fb_pixel_writer.md
# fb_pixel_writer

Consumer end of the drawing-engine pixel interface. Accepts the `x`, `y`, `drawing` pixel stream that the shape drawers emit, throttles them through their `oe` input, clips off-screen coordinates, converts on-screen pixels to linear framebuffer addresses, and buffers them in a small FIFO in front of a framebuffer write port with valid/ready flow control. Sits between any shape drawer and the framebuffer memory arbiter.

## Interface

Parameters:
- `CORDW`, 16: signed coordinate width; matches the drawers.
- `COLRW`, 4: colour width.
- `WIDTH`, 320: framebuffer width in pixels.
- `HEIGHT`, 180: framebuffer height in pixels.
- `ADDRW`, 16: address width; must satisfy 2^ADDRW >= WIDTH*HEIGHT.
- `DEPTH`, 4: FIFO entries; power of two, >= 4.

Ports:
- `clk` in 1: clock; single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `x`, `y` in CORDW (signed): pixel coordinate from drawer.
- `drawing` in 1: pixel valid this cycle.
- `colr` in COLRW: pixel colour, sampled with `drawing`.
- `oe` out 1: output enable to drawer.
- `fb_we` out 1: write request valid.
- `fb_addr` out ADDRW: linear address `y*WIDTH + x`.
- `fb_colr` out COLRW: write data.
- `fb_ready` in 1: framebuffer accepts write when high with `fb_we`.
- `clear` in 1: synchronous clear of `overflow` and `clip_cnt`.
- `idle` out 1: stage and FIFO empty.
- `overflow` out 1: sticky; pixel lost.
- `clip_cnt` out 16: clipped-pixel count (see Configuration).

## Operation

- Stage 1 (input register): on each edge with `drawing`=1, test `0 <= x < WIDTH` and `0 <= y < HEIGHT` (signed compares). In range: register `addr = y*WIDTH + x` (truncated to ADDRW; multiply by constant) and `colr`, set `stage_valid`. Out of range: discard, no stage entry.
- Stage 2 (FIFO): a valid stage entry is pushed into the FIFO on the next edge; `stage_valid` clears unless a new pixel is captured the same edge.
- Output: FIFO head drives `fb_addr`/`fb_colr`; `fb_we` = FIFO non-empty. Pop on edge where `fb_we && fb_ready`. `fb_addr`/`fb_colr` stable while `fb_we` high and not accepted.
- Flow control: occupancy = FIFO count + `stage_valid`; `oe` = occupancy <= DEPTH-2 (combinational). Margin covers the drawer's one-cycle response to `oe`.
- Overflow: if a push arrives while FIFO full (drawer ignored `oe`), the entry is dropped, `overflow` sets and holds until `clear` or reset. Simultaneous push and pop on full FIFO is not overflow.
- Pop and push same edge: count unchanged.
- `clear` and a new clip event same edge: `clear` wins, counter reads 0.
- `idle` = !`stage_valid` && FIFO empty.

## Timing

- Reset values: `oe`=1, `fb_we`=0, `fb_addr`=0, `fb_colr`=0, `idle`=1, `overflow`=0, `clip_cnt`=0; FIFO pointers and `stage_valid` cleared. Reset mid-operation discards all buffered pixels immediately (asynchronous).
- Latency: pixel sampled at edge E0 -> `stage_valid` after E0 -> in FIFO after E1 -> `fb_we` high after E1 (2 edges, FIFO previously empty).
- Throughput: one pixel per cycle sustained when `fb_ready` held high.
- `oe` responds to occupancy in the same cycle; drawer may deliver at most one more pixel after `oe` falls.

## Configuration

- `FB_WRITER_CLIP_CNT_EN` defined: `clip_cnt` increments on each clipped `drawing` pixel, saturating at 16'hFFFF; cleared by `clear`.
- Not defined: counter logic omitted; `clip_cnt` tied to 0.

## Test plan

- Single pixel (3,2), colr 4'hA, `fb_ready`=1 -> `fb_we` high exactly one cycle, 2 edges after sample, `fb_addr`=643, `fb_colr`=4'hA; `idle` returns 1.
- Row of 8 pixels x=0..7, y=179, `fb_ready`=1 -> 8 consecutive writes, addresses 57280..57287, `oe` never falls.
- Same row with `fb_ready`=0 -> `oe` falls once occupancy reaches 3; no `overflow`; release `fb_ready` -> all 8 written in order.
- Pixels (-1,0), (320,5), (5,180), (10,10) with macro defined -> only addr 3210 written; `clip_cnt`=3; `clear` -> 0. Without macro `clip_cnt` stays 0.
- Drive `drawing` continuously ignoring `oe`, `fb_ready`=0 -> FIFO holds 4 entries, `overflow`=1 sticky, first 4 pixels written intact after release.
- Assert `rst_n`=0 with 3 buffered pixels -> `fb_we`=0, `idle`=1, `oe`=1 immediately; no writes after release.
